// File: rtl/mc_defs.sv
// Shared constants for the multi-cycle MIPS controller: opcode/funct values,
// FSM state encoding, datapath mux/ALU encodings and the instruction classes
// produced by the decoder.
package mc_defs;

    localparam int unsigned OP_W    = 6;
    localparam int unsigned FUNCT_W = 6;
    localparam int unsigned STATE_W = 3;
    localparam int unsigned SEL_W   = 2;

    // Primary opcodes (IR[31:26])
    localparam logic [OP_W-1:0] OP_RTYPE = 6'h00;
    localparam logic [OP_W-1:0] OP_J     = 6'h02;
    localparam logic [OP_W-1:0] OP_JAL   = 6'h03;
    localparam logic [OP_W-1:0] OP_BEQ   = 6'h04;
    localparam logic [OP_W-1:0] OP_ORI   = 6'h0D;
    localparam logic [OP_W-1:0] OP_LUI   = 6'h0F;
    localparam logic [OP_W-1:0] OP_LW    = 6'h23;
    localparam logic [OP_W-1:0] OP_SW    = 6'h2B;

    // R-type function codes (IR[5:0])
    localparam logic [FUNCT_W-1:0] FN_NOP  = 6'h00;
    localparam logic [FUNCT_W-1:0] FN_JR   = 6'h08;
    localparam logic [FUNCT_W-1:0] FN_ADDU = 6'h21;
    localparam logic [FUNCT_W-1:0] FN_SUBU = 6'h23;

    typedef enum logic [STATE_W-1:0] {
        ST_FETCH = 3'd0,
        ST_DCD   = 3'd1,
        ST_EXE   = 3'd2,
        ST_MEM   = 3'd3,
        ST_WB    = 3'd4
    } state_t;

    typedef enum logic [SEL_W-1:0] {
        ALU_ADD = 2'd0,
        ALU_SUB = 2'd1,
        ALU_OR  = 2'd2,
        ALU_LUI = 2'd3
    } alu_op_t;

    typedef enum logic [SEL_W-1:0] {
        PC_PLUS4  = 2'd0,
        PC_BRANCH = 2'd1,
        PC_JUMP   = 2'd2,
        PC_REG    = 2'd3
    } pc_src_t;

    typedef enum logic [SEL_W-1:0] {
        RD_RT = 2'd0,
        RD_RD = 2'd1,
        RD_RA = 2'd2
    } reg_dst_t;

    typedef enum logic [SEL_W-1:0] {
        WD_ALU  = 2'd0,
        WD_MEM  = 2'd1,
        WD_LINK = 2'd2
    } wd_src_t;

    typedef enum logic [3:0] {
        CL_ADDU,
        CL_SUBU,
        CL_ORI,
        CL_LUI,
        CL_LW,
        CL_SW,
        CL_BEQ,
        CL_J,
        CL_JAL,
        CL_JR,
        CL_NOP,
        CL_ILLEGAL
    } instr_class_t;

endpackage

// File: rtl/mc_ctrl_if.sv
// Controller <-> datapath bundle.
//   master : controller side (consumes IR fields, zero and ready strobes;
//            drives write enables, mux selects, debug state and illegal flag)
//   slave  : datapath side (mirror image)
interface mc_ctrl_if;
    import mc_defs::*;

    logic [OP_W-1:0]    op;
    logic [FUNCT_W-1:0] funct;
    logic               zero;
    logic               im_ready;
    logic               dm_ready;

    logic               pc_we;
    logic [SEL_W-1:0]   pc_src;
    logic               ir_we;
    logic               reg_we;
    logic [SEL_W-1:0]   reg_dst;
    logic [SEL_W-1:0]   wd_src;
    logic               alu_src_b;
    logic               ext_op;
    logic [SEL_W-1:0]   alu_op;
    logic               dm_re;
    logic               dm_we;
    logic [STATE_W-1:0] state_o;
    logic               illegal;

    modport master (
        input  op, funct, zero, im_ready, dm_ready,
        output pc_we, pc_src, ir_we, reg_we, reg_dst, wd_src,
               alu_src_b, ext_op, alu_op, dm_re, dm_we, state_o, illegal
    );

    modport slave (
        output op, funct, zero, im_ready, dm_ready,
        input  pc_we, pc_src, ir_we, reg_we, reg_dst, wd_src,
               alu_src_b, ext_op, alu_op, dm_re, dm_we, state_o, illegal
    );

endinterface

// File: rtl/mc_decode.sv
// Pure combinational instruction classifier.
//   op, funct : IR[31:26], IR[5:0]
//   cls_c     : decoded instruction class (CL_ILLEGAL for anything unsupported)
module mc_decode
    import mc_defs::*;
(
    input  logic [OP_W-1:0]    op,
    input  logic [FUNCT_W-1:0] funct,
    output instr_class_t       cls_c
);

    always_comb begin
        cls_c = CL_ILLEGAL;
        case (op)
            OP_RTYPE: begin
                case (funct)
                    FN_ADDU: cls_c = CL_ADDU;
                    FN_SUBU: cls_c = CL_SUBU;
                    FN_JR:   cls_c = CL_JR;
                    FN_NOP:  cls_c = CL_NOP;
                    default: cls_c = CL_ILLEGAL;
                endcase
            end
            OP_ORI:  cls_c = CL_ORI;
            OP_LUI:  cls_c = CL_LUI;
            OP_LW:   cls_c = CL_LW;
            OP_SW:   cls_c = CL_SW;
            OP_BEQ:  cls_c = CL_BEQ;
            OP_J:    cls_c = CL_J;
            OP_JAL:  cls_c = CL_JAL;
            default: cls_c = CL_ILLEGAL;
        endcase
    end

endmodule

// File: rtl/mc_ctrl.sv
// Multi-cycle control FSM for the shared MIPS datapath.
//   clk, reset : rising-edge clock, synchronous active-high reset
//   bus        : mc_ctrl_if master -- op/funct/zero/im_ready/dm_ready in;
//                write enables, mux selects, ALU/EXT controls, DM requests,
//                state_o (debug) and sticky illegal flag out
// State and illegal are registered; the remaining outputs are decoded from
// state plus instruction class and are forced low while reset is high.
module mc_ctrl
    import mc_defs::*;
(
    input  logic      clk,
    input  logic      reset,
    mc_ctrl_if.master bus
);

    state_t       state_q;
    state_t       state_d;
    logic         illegal_q;
    instr_class_t cls;

    logic     pc_we_c;
    pc_src_t  pc_src_c;
    logic     ir_we_c;
    logic     reg_we_c;
    reg_dst_t reg_dst_c;
    wd_src_t  wd_src_c;
    logic     alu_src_b_c;
    logic     ext_op_c;
    alu_op_t  alu_op_c;
    logic     dm_re_c;
    logic     dm_we_c;

    // IR is stable from DCD until the next fetch, so decode straight from it
    mc_decode u_decode (
        .op    (bus.op),
        .funct (bus.funct),
        .cls_c (cls)
    );

    // State and sticky illegal flag
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_FETCH;
            illegal_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == ST_DCD && cls == CL_ILLEGAL) begin
                illegal_q <= 1'b1;
            end
        end
    end

    // Next state and datapath controls
    always_comb begin
        state_d     = state_q;
        pc_we_c     = 1'b0;
        pc_src_c    = PC_PLUS4;
        ir_we_c     = 1'b0;
        reg_we_c    = 1'b0;
        reg_dst_c   = RD_RT;
        wd_src_c    = WD_ALU;
        alu_src_b_c = 1'b0;
        ext_op_c    = 1'b0;
        alu_op_c    = ALU_ADD;
        dm_re_c     = 1'b0;
        dm_we_c     = 1'b0;

        // ALU/EXT controls stay put from EXE through WB (no ALUOut register)
        if (state_q == ST_EXE || state_q == ST_MEM || state_q == ST_WB) begin
            case (cls)
                CL_ADDU: alu_op_c = ALU_ADD;
                CL_SUBU: alu_op_c = ALU_SUB;
                CL_ORI: begin
                    alu_op_c    = ALU_OR;
                    alu_src_b_c = 1'b1;
                end
                CL_LUI: begin
                    alu_op_c    = ALU_LUI;
                    alu_src_b_c = 1'b1;
                end
                CL_LW, CL_SW: begin
                    alu_op_c    = ALU_ADD;
                    alu_src_b_c = 1'b1;
                    ext_op_c    = 1'b1;
                end
                CL_BEQ: begin
                    alu_op_c = ALU_SUB;
                    ext_op_c = 1'b1;
                end
                default: ;
            endcase
        end

        case (state_q)
            ST_FETCH: begin
                ir_we_c = bus.im_ready;
                pc_we_c = bus.im_ready;
                if (bus.im_ready) begin
                    state_d = ST_DCD;
                end
            end

            ST_DCD: begin
                state_d = ST_EXE;
                case (cls)
                    CL_J: begin
                        pc_we_c  = 1'b1;
                        pc_src_c = PC_JUMP;
                        state_d  = ST_FETCH;
                    end
                    CL_JAL: begin
                        pc_we_c   = 1'b1;
                        pc_src_c  = PC_JUMP;
                        reg_we_c  = 1'b1;
                        reg_dst_c = RD_RA;
                        wd_src_c  = WD_LINK;
                        state_d   = ST_FETCH;
                    end
                    CL_JR: begin
                        pc_we_c  = 1'b1;
                        pc_src_c = PC_REG;
                        state_d  = ST_FETCH;
                    end
                    CL_NOP, CL_ILLEGAL: state_d = ST_FETCH;
                    default: ;
                endcase
            end

            ST_EXE: begin
                case (cls)
                    CL_ADDU, CL_SUBU, CL_ORI, CL_LUI: state_d = ST_WB;
                    CL_LW, CL_SW:                     state_d = ST_MEM;
                    CL_BEQ: begin
                        pc_src_c = PC_BRANCH;
                        pc_we_c  = bus.zero;
                        state_d  = ST_FETCH;
                    end
                    default: state_d = ST_FETCH;
                endcase
            end

            // Request held continuously until the memory reports completion
            ST_MEM: begin
                case (cls)
                    CL_LW: begin
                        dm_re_c = 1'b1;
                        if (bus.dm_ready) begin
                            state_d = ST_WB;
                        end
                    end
                    CL_SW: begin
                        dm_we_c = 1'b1;
                        if (bus.dm_ready) begin
                            state_d = ST_FETCH;
                        end
                    end
                    default: state_d = ST_FETCH;
                endcase
            end

            ST_WB: begin
                reg_we_c  = 1'b1;
                reg_dst_c = (cls == CL_ADDU || cls == CL_SUBU) ? RD_RD : RD_RT;
                wd_src_c  = (cls == CL_LW) ? WD_MEM : WD_ALU;
                state_d   = ST_FETCH;
            end

            default: state_d = ST_FETCH;
        endcase

        // Reset kills every strobe in the same cycle, including a pending DM access
        if (reset) begin
            pc_we_c     = 1'b0;
            pc_src_c    = PC_PLUS4;
            ir_we_c     = 1'b0;
            reg_we_c    = 1'b0;
            reg_dst_c   = RD_RT;
            wd_src_c    = WD_ALU;
            alu_src_b_c = 1'b0;
            ext_op_c    = 1'b0;
            alu_op_c    = ALU_ADD;
            dm_re_c     = 1'b0;
            dm_we_c     = 1'b0;
        end
    end

    assign bus.pc_we     = pc_we_c;
    assign bus.pc_src    = pc_src_c;
    assign bus.ir_we     = ir_we_c;
    assign bus.reg_we    = reg_we_c;
    assign bus.reg_dst   = reg_dst_c;
    assign bus.wd_src    = wd_src_c;
    assign bus.alu_src_b = alu_src_b_c;
    assign bus.ext_op    = ext_op_c;
    assign bus.alu_op    = alu_op_c;
    assign bus.dm_re     = dm_re_c;
    assign bus.dm_we     = dm_we_c;
    assign bus.state_o   = state_q;
    assign bus.illegal   = illegal_q & ~reset;

endmodule

// File: tb/tb_mc_ctrl.sv
// Cycle-accurate scoreboard bench for mc_ctrl: each instruction is expanded
// into per-cycle input vectors and expected control words, then replayed.
module tb_mc_ctrl;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    mc_ctrl_if bus ();

    mc_ctrl dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct packed {
        logic       rst;
        logic [5:0] op;
        logic [5:0] funct;
        logic       zero;
        logic       im_ready;
        logic       dm_ready;
    } stim_t;

    typedef struct packed {
        logic [2:0] st;
        logic       pc_we;
        logic [1:0] pc_src;
        logic       ir_we;
        logic       reg_we;
        logic [1:0] reg_dst;
        logic [1:0] wd_src;
        logic       alu_src_b;
        logic       ext_op;
        logic [1:0] alu_op;
        logic       dm_re;
        logic       dm_we;
        logic       illegal;
    } exp_t;

    stim_t stim_q[$];
    exp_t  exp_q[$];
    int    n_vec = 0;
    int    n_err = 0;
    bit    ill   = 1'b0;

    // Instruction kinds: 0 addu 1 subu 2 ori 3 lui 4 lw 5 sw 6 beq 7 j 8 jal 9 jr 10 nop 11 illegal
    function automatic int kind(logic [5:0] op, logic [5:0] funct);
        if (op == 6'h00) begin
            if (funct == 6'h21) return 0;
            if (funct == 6'h23) return 1;
            if (funct == 6'h08) return 9;
            if (funct == 6'h00) return 10;
            return 11;
        end
        if (op == 6'h0D) return 2;
        if (op == 6'h0F) return 3;
        if (op == 6'h23) return 4;
        if (op == 6'h2B) return 5;
        if (op == 6'h04) return 6;
        if (op == 6'h02) return 7;
        if (op == 6'h03) return 8;
        return 11;
    endfunction

    function automatic exp_t base(logic [2:0] st);
        exp_t e;
        e = '0;
        e.st = st;
        e.illegal = ill;
        return e;
    endfunction

    function automatic exp_t alu_hold(exp_t ein, int k);
        exp_t e;
        e = ein;
        case (k)
            0: begin e.alu_op = 2'd0; e.alu_src_b = 1'b0; end
            1: begin e.alu_op = 2'd1; e.alu_src_b = 1'b0; end
            2: begin e.alu_op = 2'd2; e.alu_src_b = 1'b1; e.ext_op = 1'b0; end
            3: begin e.alu_op = 2'd3; e.alu_src_b = 1'b1; e.ext_op = 1'b0; end
            4, 5: begin e.alu_op = 2'd0; e.alu_src_b = 1'b1; e.ext_op = 1'b1; end
            6: begin e.alu_op = 2'd1; e.alu_src_b = 1'b0; e.ext_op = 1'b1; end
            default: ;
        endcase
        return e;
    endfunction

    task automatic push(stim_t s, exp_t e);
        stim_q.push_back(s);
        exp_q.push_back(e);
    endtask

    task automatic chk(string tag, logic [31:0] got, logic [31:0] want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, got, want);
        end
    endtask

    // One reset cycle with the FSM sitting in FETCH
    task automatic gen_reset();
        stim_t s;
        exp_t  e;
        s = '0;
        s.rst = 1'b1;
        e = '0;
        push(s, e);
        ill = 1'b0;
    endtask

    // Expand one instruction into cycles; rst_mem >= 0 fires reset in that MEM cycle
    task automatic gen(logic [5:0] op, logic [5:0] funct, int im_wait, int dm_wait,
                       logic z, int rst_mem = -1);
        stim_t s;
        exp_t  e;
        int    k;
        k = kind(op, funct);
        s = '0;
        s.op = op;
        s.funct = funct;
        s.zero = z;
        s.dm_ready = 1'b1;

        for (int i = 0; i < im_wait; i++) push(s, base(3'd0));
        s.im_ready = 1'b1;
        e = base(3'd0);
        e.ir_we = 1'b1;
        e.pc_we = 1'b1;
        push(s, e);

        e = base(3'd1);
        case (k)
            7: begin e.pc_we = 1'b1; e.pc_src = 2'd2; end
            8: begin
                e.pc_we = 1'b1; e.pc_src = 2'd2;
                e.reg_we = 1'b1; e.reg_dst = 2'd2; e.wd_src = 2'd2;
            end
            9: begin e.pc_we = 1'b1; e.pc_src = 2'd3; end
            default: ;
        endcase
        push(s, e);
        if (k == 11) ill = 1'b1;
        if (k >= 7) return;

        e = alu_hold(base(3'd2), k);
        if (k == 6) begin
            e.pc_src = 2'd1;
            e.pc_we = z;
        end
        push(s, e);
        if (k == 6) return;

        if (k == 4 || k == 5) begin
            for (int i = 0; i <= dm_wait; i++) begin
                s.dm_ready = (i == dm_wait);
                if (i == rst_mem) begin
                    s.rst = 1'b1;
                    s.dm_ready = 1'b0;
                    e = base(3'd3);
                    e.illegal = 1'b0;
                    push(s, e);
                    ill = 1'b0;
                    return;
                end
                e = alu_hold(base(3'd3), k);
                if (k == 4) e.dm_re = 1'b1;
                else        e.dm_we = 1'b1;
                push(s, e);
            end
            if (k == 5) return;
        end

        s.dm_ready = 1'b1;
        e = alu_hold(base(3'd4), k);
        e.reg_we = 1'b1;
        e.reg_dst = (k <= 1) ? 2'd1 : 2'd0;
        e.wd_src = (k == 4) ? 2'd1 : 2'd0;
        push(s, e);
    endtask

    initial begin
        stim_t s;
        exp_t  e;
        exp_t  g;
        int    cyc;

        reset        = 1'b1;
        bus.op       = '0;
        bus.funct    = '0;
        bus.zero     = 1'b0;
        bus.im_ready = 1'b0;
        bus.dm_ready = 1'b0;
        repeat (2) @(posedge clk);

        gen_reset();
        gen(6'h00, 6'h21, 0, 0, 1'b0);        // addu
        gen(6'h23, 6'h00, 0, 3, 1'b0);        // lw, 3 DM wait cycles
        gen(6'h04, 6'h00, 0, 0, 1'b0);        // beq not taken
        gen(6'h04, 6'h00, 0, 0, 1'b1);        // beq taken
        gen(6'h03, 6'h00, 0, 0, 1'b0);        // jal
        gen(6'h02, 6'h00, 0, 0, 1'b1);        // j
        gen(6'h00, 6'h08, 0, 0, 1'b0);        // jr
        gen(6'h00, 6'h00, 0, 0, 1'b0);        // nop
        gen(6'h00, 6'h23, 2, 0, 1'b1);        // subu, 2 IM wait cycles
        gen(6'h0D, 6'h11, 0, 0, 1'b0);        // ori
        gen(6'h0F, 6'h00, 1, 0, 1'b0);        // lui
        gen(6'h2B, 6'h00, 0, 1, 1'b0);        // sw, 1 DM wait cycle
        gen(6'h3F, 6'h00, 0, 0, 1'b0);        // illegal opcode
        gen(6'h00, 6'h21, 0, 0, 1'b0);        // addu, flag stays set
        gen(6'h00, 6'h2A, 0, 0, 1'b0);        // illegal funct
        gen_reset();
        gen(6'h2B, 6'h00, 0, 3, 1'b0, 1);     // sw, reset in 2nd MEM cycle
        gen(6'h00, 6'h21, 1, 0, 1'b0);        // addu after reset

        cyc = 0;
        while (stim_q.size() > 0) begin
            s = stim_q.pop_front();
            #1;
            reset        = s.rst;
            bus.op       = s.op;
            bus.funct    = s.funct;
            bus.zero     = s.zero;
            bus.im_ready = s.im_ready;
            bus.dm_ready = s.dm_ready;
            @(negedge clk);
            e = exp_q.pop_front();
            g.st        = bus.state_o;
            g.pc_we     = bus.pc_we;
            g.pc_src    = bus.pc_src;
            g.ir_we     = bus.ir_we;
            g.reg_we    = bus.reg_we;
            g.reg_dst   = bus.reg_dst;
            g.wd_src    = bus.wd_src;
            g.alu_src_b = bus.alu_src_b;
            g.ext_op    = bus.ext_op;
            g.alu_op    = bus.alu_op;
            g.dm_re     = bus.dm_re;
            g.dm_we     = bus.dm_we;
            g.illegal   = bus.illegal;
            chk($sformatf("cyc%0d_st%0d", cyc, e.st), 32'(g), 32'(e));
            cyc++;
            @(posedge clk);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
